// File: rtl/recovered_clock_gen.sv
// Regenerates a recovered clock in the system domain from a tracked half-rate,
// phase-aligned to a resync event and trimmed by one-shot drift corrections.
module recovered_clock_gen #(
   parameter int RATE_WIDTH  = 16,
   parameter int DRIFT_WIDTH = 8
) (
   input  logic                   sys_clk_i,
   input  logic                   sys_rst_i,
   input  logic                   gen_en_i,
   input  logic                   clear_state_i,
   input  logic                   active_rate_valid_i,
   input  logic [RATE_WIDTH-1:0]  active_rate_i,
   input  logic                   locked_in_i,
   input  logic                   resync_event_i,
   input  logic                   drift_detected_i,
   input  logic                   drift_direction_i,
   input  logic [DRIFT_WIDTH-1:0] drift_amount_i,
   output logic                   recovered_clk_o,
   output logic                   rise_strobe_o,
   output logic                   fall_strobe_o,
   output logic                   sample_strobe_o,
   output logic                   gen_active_o,
   output logic                   correction_applied_o
);

   typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

   state_t                 state_q, state_d;
   logic [RATE_WIDTH-1:0]  cnt_q, cnt_d;
   logic [RATE_WIDTH-1:0]  len_q, len_d;
   logic [RATE_WIDTH-1:0]  cur_len_q, cur_len_d;
   logic                   clk_q, clk_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   samp_q, samp_d;
   logic                   corr_q, corr_d;
   logic                   pend_q, pend_d;
   logic                   pend_dir_q, pend_dir_d;
   logic [DRIFT_WIDTH-1:0] pend_amt_q, pend_amt_d;

   logic                   exit_req;
   logic [RATE_WIDTH-1:0]  rate_floor;
   logic [RATE_WIDTH-1:0]  base_len;
   logic [RATE_WIDTH-1:0]  amt_ext;
   logic [RATE_WIDTH-1:0]  amt_clamped;
   logic [RATE_WIDTH:0]    len_sum;
   logic [RATE_WIDTH-1:0]  len_long;
   logic [RATE_WIDTH-1:0]  len_short;
   logic [RATE_WIDTH-1:0]  new_len;

   // Length of the next half, evaluated every cycle but only used at a boundary.
   always_comb begin
      exit_req    = clear_state_i | ~gen_en_i | ~locked_in_i;
      rate_floor  = (active_rate_i < RATE_WIDTH'(2)) ? RATE_WIDTH'(2) : active_rate_i;
      base_len    = active_rate_valid_i ? rate_floor : len_q;
      amt_ext     = RATE_WIDTH'(pend_amt_q);
      amt_clamped = (amt_ext < (base_len >> 1)) ? amt_ext : (base_len >> 1);
      len_sum     = {1'b0, base_len} + {1'b0, amt_clamped};
      len_long    = len_sum[RATE_WIDTH] ? {RATE_WIDTH{1'b1}} : len_sum[RATE_WIDTH-1:0];
      len_short   = (base_len > amt_clamped) ? (base_len - amt_clamped) : RATE_WIDTH'(1);
      if (pend_q) begin
         new_len = pend_dir_q ? len_long : len_short;
      end else begin
         new_len = base_len;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      cur_len_d  = cur_len_q;
      clk_d      = clk_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      samp_d     = 1'b0;
      corr_d     = 1'b0;
      pend_d     = pend_q;
      pend_dir_d = pend_dir_q;
      pend_amt_d = pend_amt_q;

      case (state_q)
         IDLE: begin
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (gen_en_i && locked_in_i && active_rate_valid_i && !clear_state_i) begin
               state_d = ALIGN;
            end
         end

         ALIGN: begin
            if (exit_req) begin
               state_d = IDLE;
               clk_d   = 1'b0;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               if (drift_detected_i) begin
                  pend_d     = 1'b1;
                  pend_dir_d = drift_direction_i;
                  pend_amt_d = drift_amount_i;
               end
               if (resync_event_i) begin
                  state_d   = RUN;
                  len_d     = rate_floor;
                  cur_len_d = rate_floor;
                  cnt_d     = rate_floor - RATE_WIDTH'(1);
                  clk_d     = 1'b1;
                  rise_d    = 1'b1;
               end
            end
         end

         RUN: begin
            if (exit_req) begin
               state_d = IDLE;
               clk_d   = 1'b0;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (cnt_q == '0) begin
               // A report landing on the boundary stays pending for the next one.
               clk_d     = ~clk_q;
               rise_d    = ~clk_q;
               fall_d    = clk_q;
               len_d     = base_len;
               cur_len_d = new_len;
               cnt_d     = new_len - RATE_WIDTH'(1);
               corr_d    = pend_q;
               pend_d    = drift_detected_i;
               if (drift_detected_i) begin
                  pend_dir_d = drift_direction_i;
                  pend_amt_d = drift_amount_i;
               end
            end else begin
               cnt_d  = cnt_q - RATE_WIDTH'(1);
               samp_d = clk_q && (cnt_q == (cur_len_q >> 1));
               if (drift_detected_i) begin
                  pend_d     = 1'b1;
                  pend_dir_d = drift_direction_i;
                  pend_amt_d = drift_amount_i;
               end
            end
         end

         default: begin
            state_d = IDLE;
            clk_d   = 1'b0;
            pend_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         cur_len_q  <= '0;
         clk_q      <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         samp_q     <= 1'b0;
         corr_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_dir_q <= 1'b0;
         pend_amt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         cur_len_q  <= cur_len_d;
         clk_q      <= clk_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         samp_q     <= samp_d;
         corr_q     <= corr_d;
         pend_q     <= pend_d;
         pend_dir_q <= pend_dir_d;
         pend_amt_q <= pend_amt_d;
      end
   end

   assign recovered_clk_o      = clk_q;
   assign rise_strobe_o        = rise_q;
   assign fall_strobe_o        = fall_q;
   assign sample_strobe_o      = samp_q;
   assign correction_applied_o = corr_q;
   assign gen_active_o         = (state_q == RUN);

endmodule

// File: tb/tb_recovered_clock_gen.sv
// Scoreboard bench for recovered_clock_gen: a timeline model predicts every
// output cycle, a monitor compares on the falling edge.
module tb_recovered_clock_gen;

   localparam int RW = 16;
   localparam int DW = 8;

   logic          sys_clk;
   logic          sys_rst;
   logic          gen_en;
   logic          clear_state;
   logic          rate_valid;
   logic [RW-1:0] rate;
   logic          locked;
   logic          resync;
   logic          drift_det;
   logic          drift_dir;
   logic [DW-1:0] drift_amt;
   logic          rec_clk;
   logic          rise_s;
   logic          fall_s;
   logic          samp_s;
   logic          active;
   logic          corr;

   int checks = 0;
   int passed = 0;

   // Expected {clk, rise, fall, sample, active, correction} per cycle.
   logic [5:0] exp_q[$];

   recovered_clock_gen #(.RATE_WIDTH(RW), .DRIFT_WIDTH(DW)) dut (
      .sys_clk_i            (sys_clk),
      .sys_rst_i            (sys_rst),
      .gen_en_i             (gen_en),
      .clear_state_i        (clear_state),
      .active_rate_valid_i  (rate_valid),
      .active_rate_i        (rate),
      .locked_in_i          (locked),
      .resync_event_i       (resync),
      .drift_detected_i     (drift_det),
      .drift_direction_i    (drift_dir),
      .drift_amount_i       (drift_amt),
      .recovered_clk_o      (rec_clk),
      .rise_strobe_o        (rise_s),
      .fall_strobe_o        (fall_s),
      .sample_strobe_o      (samp_s),
      .gen_active_o         (active),
      .correction_applied_o (corr)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Model keeps absolute cycle numbers: half start time and half length.
   int m_mode = 0;
   int m_cycle = 0;
   int m_hs = 0;
   int m_hl = 0;
   int m_base = 0;
   int m_pamt = 0;
   bit m_high = 0;
   bit m_pend = 0;
   bit m_pdir = 0;

   function automatic int floor2(input int r);
      return (r < 2) ? 2 : r;
   endfunction

   always @(posedge sys_clk) begin : model
      bit ex, c_clk, c_rise, c_fall, c_samp, c_corr;
      int b, a, len;
      ex = clear_state || !gen_en || !locked;
      c_clk = 0; c_rise = 0; c_fall = 0; c_samp = 0; c_corr = 0;
      if (sys_rst) begin
         m_mode = 0; m_high = 0; m_base = 0; m_pend = 0;
      end else begin
         case (m_mode)
            0: begin
               m_pend = 0;
               if (gen_en && locked && rate_valid && !clear_state) m_mode = 1;
            end
            1: begin
               if (ex) begin
                  m_mode = 0; m_high = 0; m_pend = 0;
               end else begin
                  if (drift_det) begin
                     m_pend = 1; m_pdir = drift_dir; m_pamt = int'(drift_amt);
                  end
                  if (resync) begin
                     m_base = floor2(int'(rate));
                     m_high = 1; m_hs = m_cycle + 1; m_hl = m_base;
                     c_clk = 1; c_rise = 1; m_mode = 2;
                  end
               end
            end
            default: begin
               if (ex) begin
                  m_mode = 0; m_high = 0; m_pend = 0;
               end else if (m_cycle == m_hs + m_hl - 1) begin
                  b = rate_valid ? floor2(int'(rate)) : m_base;
                  len = b;
                  if (m_pend) begin
                     a = (m_pamt < b / 2) ? m_pamt : b / 2;
                     if (m_pdir) len = (b + a > 65535) ? 65535 : b + a;
                     else        len = (b - a < 1) ? 1 : b - a;
                     c_corr = 1;
                  end
                  m_base = b;
                  m_pend = 0;
                  m_high = !m_high;
                  m_hs = m_cycle + 1;
                  m_hl = len;
                  c_clk = m_high; c_rise = m_high; c_fall = !m_high;
                  if (drift_det) begin
                     m_pend = 1; m_pdir = drift_dir; m_pamt = int'(drift_amt);
                  end
               end else begin
                  c_clk = m_high;
                  if (m_high && m_hl >= 2 && (m_cycle + 1 == m_hs + m_hl - m_hl / 2)) c_samp = 1;
                  if (drift_det) begin
                     m_pend = 1; m_pdir = drift_dir; m_pamt = int'(drift_amt);
                  end
               end
            end
         endcase
      end
      exp_q.push_back({c_clk, c_rise, c_fall, c_samp, (m_mode == 2), c_corr});
      m_cycle++;
   end

   always @(negedge sys_clk) begin : monitor
      logic [5:0] e, a;
      a = {rec_clk, rise_s, fall_s, samp_s, active, corr};
      checks++;
      if (exp_q.size() == 0) begin
         $display("[TB] FAIL scoreboard_empty at %0t: got %b, nothing expected", $time, a);
      end else begin
         e = exp_q.pop_front();
         if (a === e) passed++;
         else $display("[TB] FAIL outputs at %0t: got clk/rise/fall/samp/act/corr=%b required %b",
                       $time, a, e);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic pulse_resync();
      resync = 1'b1; step(1); resync = 1'b0;
   endtask

   task automatic pulse_drift(input logic dir, input int amt);
      drift_det = 1'b1; drift_dir = dir; drift_amt = DW'(amt);
      step(1);
      drift_det = 1'b0;
   endtask

   task automatic async_reset();
      step(1);
      #1 sys_rst = 1'b1;
      #1;
      checks++;
      if ({rec_clk, rise_s, fall_s, samp_s, active, corr} === 6'b0) passed++;
      else $display("[TB] FAIL async_reset: got %b required 000000",
                    {rec_clk, rise_s, fall_s, samp_s, active, corr});
      step(2);
      sys_rst = 1'b0;
   endtask

   initial begin : stimulus
      sys_rst = 1'b1;
      gen_en = 0; clear_state = 0; rate_valid = 0; rate = '0; locked = 0;
      resync = 0; drift_det = 0; drift_dir = 0; drift_amt = '0;
      step(3);
      sys_rst = 1'b0;

      // Basic run at rate 4
      gen_en = 1; locked = 1; rate_valid = 1; rate = 16'd4;
      step(3);
      pulse_resync();
      step(20);

      // Lengthen at rate 6
      rate = 16'd6;
      step(13);
      pulse_drift(1'b1, 2);
      step(30);

      // Shorten with clamp, then rate 2
      rate = 16'd4;
      step(5);
      pulse_drift(1'b0, 10);
      step(20);
      rate = 16'd2;
      step(3);
      pulse_drift(1'b0, 5);
      step(20);

      // Mid-half rate change, then held rate
      rate = 16'd4;
      step(12);
      rate = 16'd10;
      step(30);
      rate_valid = 0;
      step(45);
      rate_valid = 1;

      // Forced stop and re-lock
      locked = 0;
      step(1);
      locked = 1;
      step(6);
      pulse_resync();
      step(20);

      // Async reset mid-run
      async_reset();
      step(3);
      pulse_resync();
      step(15);

      // Clear with a simultaneous drift report, restart at rate 0
      clear_state = 1; drift_det = 1; drift_dir = 1; drift_amt = 8'd3;
      step(1);
      clear_state = 0; drift_det = 0;
      rate = 16'd0;
      step(3);
      pulse_resync();
      step(20);
      rate = 16'd1;
      step(20);

      // Randomized traffic
      for (int i = 0; i < 6000; i++) begin
         gen_en      = ($urandom_range(0, 299) != 0);
         locked      = ($urandom_range(0, 199) != 0);
         clear_state = ($urandom_range(0, 399) == 0);
         rate_valid  = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) rate = RW'($urandom_range(0, 12));
         resync      = ($urandom_range(0, 9) == 0);
         drift_det   = ($urandom_range(0, 14) == 0);
         drift_dir   = 1'($urandom_range(0, 1));
         drift_amt   = DW'($urandom_range(0, 12));
         if (i % 1700 == 1699) begin
            resync = 0; drift_det = 0;
            async_reset();
         end else begin
            step(1);
         end
      end
      resync = 0; drift_det = 0;
      step(3);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
